// File: rtl/output_writeback.sv
// output_writeback: buffers M systolic result rows of K lanes, then streams them to memory lane-major
//   clk        single clock, all state changes on posedge
//   rst        asynchronous active-low reset
//   Y          result row, lane k at [(k+1)*DATA_WIDTH-1 : k*DATA_WIDTH]
//   valid      Y holds a valid row this cycle
//   mem_wr_en  write strobe, accompanied by registered addr_wr/data_wr
//   addr_wr    write word address (OUTPUT_BASE + k*M + m)
//   data_wr    write data (row m, lane k)
//   busy       high while capturing or writing
//   done       one-cycle completion pulse
//   overrun    sticky: a row arrived while writing or done
module output_writeback #(
    parameter int M = 12,
    parameter int K = 5,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] OUTPUT_BASE = 32'h00003000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH*K-1:0] Y,
    input  logic                    valid,
    output logic                    mem_wr_en,
    output logic [ADDR_WIDTH-1:0]   addr_wr,
    output logic [DATA_WIDTH-1:0]   data_wr,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);
    localparam int MW = M > 1 ? $clog2(M) : 1;
    localparam int KW = K > 1 ? $clog2(K) : 1;
    typedef enum logic [1:0] {IDLE, CAPTURE, WRITE, DONE} state_t;
    state_t state_q, state_d;
    logic [MW-1:0] row_cnt_q, row_cnt_d, m_q, m_d, m_n, cap_idx;
    logic [KW-1:0] k_q, k_d, k_n;
    logic wr_en_q, wr_en_d, overrun_q, overrun_d, m_wrap, start_wr, cap_en;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH*K-1:0] buf_q [M];

    assign cap_en  = valid && (state_q == IDLE || state_q == CAPTURE);
    assign cap_idx = state_q == IDLE ? '0 : row_cnt_q;

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        k_d       = k_q;
        m_d       = m_q;
        wr_en_d   = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        start_wr  = 1'b0;
        overrun_d = overrun_q | (valid && (state_q == WRITE || state_q == DONE));
        m_wrap    = m_q == MW'(M - 1);
        m_n       = m_wrap ? '0 : m_q + 1'b1;
        k_n       = m_wrap ? k_q + 1'b1 : k_q;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    if (M == 1) start_wr = 1'b1;
                    else begin
                        state_d   = CAPTURE;
                        row_cnt_d = MW'(1);
                    end
                end
            end
            CAPTURE: begin
                if (valid) begin
                    start_wr  = row_cnt_q == MW'(M - 1);
                    row_cnt_d = start_wr ? '0 : row_cnt_q + 1'b1;
                end
            end
            WRITE: begin
                if (m_wrap && k_q == KW'(K - 1)) begin
                    state_d = DONE;
                    k_d     = '0;
                    m_d     = '0;
                end else begin
                    // Lane-major order makes the address a simple running increment
                    wr_en_d = 1'b1;
                    k_d     = k_n;
                    m_d     = m_n;
                    addr_d  = addr_q + 1'b1;
                    data_d  = buf_q[m_n][k_n * DATA_WIDTH +: DATA_WIDTH];
                end
            end
            default: state_d = IDLE;
        endcase
        if (start_wr) begin
            // With M==1 row 0 is captured on this very edge, so take it straight from Y
            state_d = WRITE;
            wr_en_d = 1'b1;
            k_d     = '0;
            m_d     = '0;
            addr_d  = OUTPUT_BASE;
            data_d  = M == 1 ? Y[DATA_WIDTH-1:0] : buf_q[0][DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            row_cnt_q <= '0;
            k_q       <= '0;
            m_q       <= '0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            k_q       <= k_d;
            m_q       <= m_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en) buf_q[cap_idx] <= Y;
    end

    assign mem_wr_en = wr_en_q;
    assign addr_wr   = addr_q;
    assign data_wr   = data_q;
    assign busy      = state_q == CAPTURE || state_q == WRITE;
    assign done      = state_q == DONE;
    assign overrun   = overrun_q;
endmodule
